psum_acc_writer: RTL and testbench

PSUM_ACC_WRITER -- requirements
Module: psum_acc_writer

---
 rtl/acc_pkg.sv | 19 +
 rtl/acc_quant.sv | 28 ++
 rtl/psum_acc_writer.sv | 125 ++++++++++++
 tb/tb_psum_acc_writer.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared package for the partial-sum accumulator/writer: FSM state
// encoding and default datapath widths.
package acc_pkg;

  localparam int PSUM_W_DEF     = 34;
  localparam int ACC_W_DEF      = 40;
  localparam int OUT_W_DEF      = 16;
  localparam int ADDR_W_DEF     = 8;
  localparam int NUM_OUT_DEF    = 256;
  localparam int FRAC_SHIFT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/acc_quant.sv
// acc_quant: arithmetic shift, optional ReLU, signed saturation to OUT_W.
// Ports: acc (ACC_W accumulator in), q (OUT_W word out). Macro PSUM_ACC_RELU_EN.
module acc_quant
  import acc_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] q
);

  logic [ACC_W-1:0] sh;
  logic             fits;

  always_comb begin
    sh = $unsigned($signed(acc) >>> FRAC_SHIFT);
`ifdef PSUM_ACC_RELU_EN
    if (sh[ACC_W-1]) sh = '0;
`endif
    // value fits when all bits above the OUT_W sign bit copy it
    fits = (&sh[ACC_W-1:OUT_W-1]) | ~(|sh[ACC_W-1:OUT_W-1]);
    if (fits) q = sh[OUT_W-1:0];
    else      q = {sh[ACC_W-1], {(OUT_W-1){~sh[ACC_W-1]}}};
  end

endmodule

// File: rtl/psum_acc_writer.sv
// psum_acc_writer: accumulates MAC partial sums per pixel, writes quantised
// result to obuf. Ports: clk, rst_n, start, psum_i/valid/last/ready,
// obuf_ena/wea/addr/din, done, ovf_o. Macro PSUM_ACC_RELU_EN adds ReLU.
module psum_acc_writer
  import acc_pkg::*;
#(
  parameter int PSUM_W     = PSUM_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int NUM_OUT    = NUM_OUT_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PSUM_W-1:0] psum_i,
  input  logic              psum_valid_i,
  input  logic              psum_last_i,
  output logic              psum_ready_o,
  output logic              obuf_ena,
  output logic              obuf_wea,
  output logic [ADDR_W-1:0] obuf_addr,
  output logic [OUT_W-1:0]  obuf_din,
  output logic              done,
  output logic              ovf_o
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_OUT - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]  ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state_q;
  state_t            state_d;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_add;
  logic [ACC_W:0]    sum;
  logic [ADDR_W-1:0] cnt_q;
  logic [OUT_W-1:0]  quant;
  logic              beat;
  logic              sat;

  assign beat = (state_q == ACCUM) && psum_valid_i;

  // one guard bit catches signed overflow of the accumulate
  assign sum = {acc_q[ACC_W-1], acc_q}
             + {{(ACC_W+1-PSUM_W){psum_i[PSUM_W-1]}}, psum_i};
  assign sat = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    acc_add = sum[ACC_W-1:0];
    if (sat) acc_add = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  // quantise the sum including the current beat so the
  // write data is ready when WRITE is entered
  acc_quant #(
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_quant (
    .acc (acc_add),
    .q   (quant)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (beat && psum_last_i) state_d = WRITE;
      WRITE:   state_d = (cnt_q == LAST_CNT) ? DONE : ACCUM;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      psum_ready_o <= 1'b0;
      obuf_ena     <= 1'b0;
      obuf_wea     <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      psum_ready_o <= (state_d == ACCUM);
      obuf_ena     <= (state_d == WRITE);
      obuf_wea     <= (state_d == WRITE);
      done         <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_o <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_o <= 1'b0;
      end
      if (beat) begin
        acc_q <= acc_add;
        if (sat) ovf_o <= 1'b1;
      end
      if (state_q == WRITE) begin
        acc_q <= '0;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf_addr <= '0;
      obuf_din  <= '0;
    end else if (beat && psum_last_i) begin
      obuf_addr <= cnt_q;
      obuf_din  <= quant;
    end
  end

endmodule

// File: tb/tb_psum_acc_writer.sv
// Testbench for psum_acc_writer with NUM_OUT=4: directed cases plus
// randomized pixels checked against an arithmetic reference model.
module tb_psum_acc_writer;

  localparam int PSUM_W     = 34;
  localparam int ACC_W      = 40;
  localparam int OUT_W      = 16;
  localparam int ADDR_W     = 8;
  localparam int NUM_OUT    = 4;
  localparam int FRAC_SHIFT = 4;

  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));
  localparam longint OUT_MAX = 32767;
  localparam longint OUT_MIN = -32768;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [PSUM_W-1:0] psum_i = '0;
  logic              psum_valid_i = 1'b0;
  logic              psum_last_i = 1'b0;
  logic              psum_ready_o;
  logic              obuf_ena;
  logic              obuf_wea;
  logic [ADDR_W-1:0] obuf_addr;
  logic [OUT_W-1:0]  obuf_din;
  logic              done;
  logic              ovf_o;

  int total = 0;
  int bad = 0;
  int g0 = 0;
  int done_cnt = 0;

  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];

  longint m_acc = 0;
  logic   m_ovf = 1'b0;
  int     m_addr = 0;

  always #5 clk = ~clk;

  psum_acc_writer #(
    .PSUM_W     (PSUM_W),
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .ADDR_W     (ADDR_W),
    .NUM_OUT    (NUM_OUT),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .psum_i       (psum_i),
    .psum_valid_i (psum_valid_i),
    .psum_last_i  (psum_last_i),
    .psum_ready_o (psum_ready_o),
    .obuf_ena     (obuf_ena),
    .obuf_wea     (obuf_wea),
    .obuf_addr    (obuf_addr),
    .obuf_din     (obuf_din),
    .done         (done),
    .ovf_o        (ovf_o)
  );

  always @(negedge clk) begin
    if (obuf_ena && obuf_wea) got_q.push_back({obuf_addr, obuf_din});
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [OUT_W-1:0] m_quant(longint a);
    longint s;
    s = a >>> FRAC_SHIFT;
`ifdef PSUM_ACC_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > OUT_MAX) s = OUT_MAX;
    if (s < OUT_MIN) s = OUT_MIN;
    return s[OUT_W-1:0];
  endfunction

  task automatic m_beat(longint p, logic last);
    longint s = m_acc + p;
    if (s > ACC_MAX) begin s = ACC_MAX; m_ovf = 1'b1; end
    else if (s < ACC_MIN) begin s = ACC_MIN; m_ovf = 1'b1; end
    m_acc = s;
    if (last) begin
      exp_q.push_back({m_addr[ADDR_W-1:0], m_quant(m_acc)});
      m_acc = 0;
      m_addr++;
    end
  endtask

  task automatic do_reset();
    start = 1'b0;
    psum_valid_i = 1'b0;
    psum_last_i = 1'b0;
    psum_i = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    g0 = got_q.size();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m_acc = 0;
    m_ovf = 1'b0;
    m_addr = 0;
    exp_q.delete();
    g0 = got_q.size();
  endtask

  task automatic send_beat(longint p, logic last);
    int n = 0;
    psum_i = p[PSUM_W-1:0];
    psum_last_i = last;
    psum_valid_i = 1'b1;
    @(negedge clk);
    while (!psum_ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (!psum_ready_o) begin
      bad++;
      $display("FAIL beat_accept: ready=%0b required 1", psum_ready_o);
    end else begin
      m_beat(p, last);
    end
    @(posedge clk);
    #1;
    psum_valid_i = 1'b0;
    psum_last_i = 1'b0;
  endtask

  task automatic wait_writes(int n);
    int c = 0;
    while (got_q.size() < g0 + n && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({psum_ready_o, obuf_ena, obuf_wea, done, ovf_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {psum_ready_o, obuf_ena, obuf_wea, done, ovf_o});
    end
    total++;
    if ({obuf_addr, obuf_din} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data: got %h required 000000",
               {obuf_addr, obuf_din});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    do_reset();
    pulse_start();
    send_beat(100, 1'b0);
    send_beat(200, 1'b0);
    send_beat(300, 1'b1);
    wait_writes(1);
    total++;
    if (got_q.size() - g0 !== 1) begin
      bad++;
      $display("FAIL basic_count: got %0d required 1", got_q.size() - g0);
    end else begin
      total++;
      if (got_q[g0] !== {8'h00, 16'h0025}) begin
        bad++;
        $display("FAIL basic_write: got %h required 000025", got_q[g0]);
      end
    end
  endtask

  task automatic test_negative();
    logic [OUT_W-1:0] req;
`ifdef PSUM_ACC_RELU_EN
    req = 16'h0000;
`else
    req = 16'hFFF6;
`endif
    do_reset();
    pulse_start();
    send_beat(-160, 1'b1);
    wait_writes(1);
    total++;
    if (got_q.size() - g0 !== 1) begin
      bad++;
      $display("FAIL neg_count: got %0d required 1", got_q.size() - g0);
    end else begin
      total++;
      if (got_q[g0] !== {8'h00, req}) begin
        bad++;
        $display("FAIL neg_write: got %h required 00%h", got_q[g0], req);
      end
    end
  endtask

  task automatic test_large();
    do_reset();
    pulse_start();
    send_beat((longint'(1) <<< 33) - 1, 1'b1);
    wait_writes(1);
    total++;
    if (got_q.size() - g0 !== 1) begin
      bad++;
      $display("FAIL large_count: got %0d required 1", got_q.size() - g0);
    end else begin
      total++;
      if (got_q[g0] !== {8'h00, 16'h7FFF}) begin
        bad++;
        $display("FAIL large_write: got %h required 007fff", got_q[g0]);
      end
    end
    total++;
    if (ovf_o !== 1'b0) begin
      bad++;
      $display("FAIL large_ovf: got %b required 0", ovf_o);
    end
  endtask

  task automatic test_layer();
    int dc0;
    do_reset();
    pulse_start();
    dc0 = done_cnt;
    for (int i = 0; i < NUM_OUT; i++) begin
      send_beat(longint'($urandom_range(0, 200000)) - 100000, 1'b1);
    end
    @(negedge clk);
    total++;
    if ({obuf_ena, obuf_wea, obuf_addr, done} !== {2'b11, 8'd3, 1'b0}) begin
      bad++;
      $display("FAIL layer_last_write: ena/wea/addr/done=%b/%b/%0d/%b required 1/1/3/0",
               obuf_ena, obuf_wea, obuf_addr, done);
    end
    @(negedge clk);
    total++;
    if ({done, obuf_ena, psum_ready_o} !== 3'b100) begin
      bad++;
      $display("FAIL layer_done: done/ena/ready=%b required 100",
               {done, obuf_ena, psum_ready_o});
    end
    @(negedge clk);
    total++;
    if ({done, psum_ready_o} !== 2'b00) begin
      bad++;
      $display("FAIL layer_idle: done/ready=%b required 00",
               {done, psum_ready_o});
    end
    @(posedge clk);
    #1;
    psum_valid_i = 1'b1;
    psum_last_i = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    psum_valid_i = 1'b0;
    psum_last_i = 1'b0;
    total++;
    if (done_cnt - dc0 !== 1) begin
      bad++;
      $display("FAIL layer_done_cnt: got %0d required 1", done_cnt - dc0);
    end
    total++;
    if (got_q.size() - g0 !== NUM_OUT) begin
      bad++;
      $display("FAIL layer_count: got %0d required %0d",
               got_q.size() - g0, NUM_OUT);
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        total++;
        if (got_q[g0+i] !== exp_q[i]) begin
          bad++;
          $display("FAIL layer_write%0d: got %h required %h",
                   i, got_q[g0+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    send_beat(50, 1'b0);
    send_beat(70, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({psum_ready_o, obuf_ena, obuf_wea, done, ovf_o,
         obuf_addr, obuf_din} !== 29'b0) begin
      bad++;
      $display("FAIL rstmid_outputs: ready=%b addr=%h din=%h required 0",
               psum_ready_o, obuf_addr, obuf_din);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    g0 = got_q.size();
    psum_i = PSUM_W'(16);
    psum_valid_i = 1'b1;
    psum_last_i = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    psum_valid_i = 1'b0;
    psum_last_i = 1'b0;
    total++;
    if (got_q.size() - g0 !== 0 || psum_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_no_write: writes=%0d ready=%b required 0/0",
               got_q.size() - g0, psum_ready_o);
    end
    pulse_start();
    send_beat(16, 1'b1);
    wait_writes(1);
    total++;
    if (got_q.size() - g0 !== 1) begin
      bad++;
      $display("FAIL rstmid_count: got %0d required 1", got_q.size() - g0);
    end else begin
      total++;
      if (got_q[g0] !== {8'h00, 16'h0001}) begin
        bad++;
        $display("FAIL rstmid_write: got %h required 000001", got_q[g0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    longint a;
    longint b;
    a = longint'($urandom_range(0, 60000));
    b = -longint'($urandom_range(1, 60000));
    do_reset();
    pulse_start();
    psum_i = a[PSUM_W-1:0];
    psum_valid_i = 1'b1;
    psum_last_i = 1'b1;
    @(negedge clk);
    m_beat(a, 1'b1);
    @(posedge clk);
    #1 psum_i = b[PSUM_W-1:0];
    @(negedge clk);
    total++;
    if ({psum_ready_o, obuf_ena, obuf_wea} !== 3'b011) begin
      bad++;
      $display("FAIL b2b_write_cycle: ready/ena/wea=%b required 011",
               {psum_ready_o, obuf_ena, obuf_wea});
    end
    @(negedge clk);
    total++;
    if (psum_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accum_ready: got %b required 1", psum_ready_o);
    end
    m_beat(b, 1'b1);
    @(posedge clk);
    #1;
    psum_valid_i = 1'b0;
    psum_last_i = 1'b0;
    wait_writes(2);
    total++;
    if (got_q.size() - g0 !== 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d required 2", got_q.size() - g0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got_q[g0+i] !== exp_q[i]) begin
          bad++;
          $display("FAIL b2b_write%0d: got %h required %h",
                   i, got_q[g0+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int dc0;
    do_reset();
    for (int layer = 0; layer < 2; layer++) begin
      pulse_start();
      dc0 = done_cnt;
      for (int px = 0; px < NUM_OUT; px++) begin
        int nb;
        nb = $urandom_range(1, 5);
        for (int b = 0; b < nb; b++) begin
          send_beat(longint'($urandom_range(0, 2097152)) - 1048576,
                    (b == nb - 1));
          if (px == 0 && b == 0 && nb > 1) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
          end
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
      end
      wait_writes(NUM_OUT);
      total++;
      if (got_q.size() - g0 !== NUM_OUT || done_cnt - dc0 !== 1) begin
        bad++;
        $display("FAIL rand_count: writes=%0d done=%0d required %0d/1",
                 got_q.size() - g0, done_cnt - dc0, NUM_OUT);
      end else begin
        for (int i = 0; i < NUM_OUT; i++) begin
          total++;
          if (got_q[g0+i] !== exp_q[i]) begin
            bad++;
            $display("FAIL rand_write%0d: got %h required %h",
                     i, got_q[g0+i], exp_q[i]);
          end
        end
      end
      total++;
      if (ovf_o !== m_ovf) begin
        bad++;
        $display("FAIL rand_ovf: got %b required %b", ovf_o, m_ovf);
      end
    end
  endtask

  task automatic test_saturate();
    int n;
    n = $urandom_range(66, 70);
    do_reset();
    pulse_start();
    for (int i = 0; i < n; i++) begin
      send_beat(-(longint'(1) <<< 33), (i == n - 1));
    end
    wait_writes(1);
    total++;
    if (got_q.size() - g0 !== 1) begin
      bad++;
      $display("FAIL sat_count: got %0d required 1", got_q.size() - g0);
    end else begin
      total++;
      if (got_q[g0] !== exp_q[0] || got_q[g0] !== {8'h00, 16'h8000}) begin
        bad++;
`ifdef PSUM_ACC_RELU_EN
        if (got_q[g0] !== exp_q[0])
`endif
        $display("FAIL sat_write: got %h required %h", got_q[g0], exp_q[0]);
      end
    end
    total++;
    if (ovf_o !== 1'b1 || m_ovf !== 1'b1) begin
      bad++;
      $display("FAIL sat_ovf: got %b required 1", ovf_o);
    end
    send_beat(5, 1'b1);
    send_beat(6, 1'b1);
    send_beat(7, 1'b1);
    wait_writes(4);
    total++;
    if (ovf_o !== 1'b1) begin
      bad++;
      $display("FAIL sat_ovf_sticky: got %b required 1", ovf_o);
    end
    pulse_start();
    @(negedge clk);
    total++;
    if (ovf_o !== 1'b0) begin
      bad++;
      $display("FAIL sat_ovf_clear: got %b required 0", ovf_o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_large();
    test_layer();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
